// File: rtl/mant_align.sv
// Significand alignment: picks the larger-exponent operand and right-shifts the smaller one bit per clock.
// Latency 1+N cycles (N = exponent difference); one op in flight, in_ready only in IDLE, out_valid held until out_ready.
module mant_align (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] Exp_A,
    input  logic [2:0] Exp_B,
    input  logic [3:0] Man_A,
    input  logic [3:0] Man_B,
    input  logic [3:0] Exp_diff,
    input  logic       Co,
    input  logic       Same_exp,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] Man_big,
    output logic [4:0] Man_small,
    output logic       Guard,
    output logic       Sticky,
    output logic [2:0] Exp_res,
    output logic       Swap
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [4:0] big_q, big_d;
    logic [4:0] small_q, small_d;
    logic       guard_q, guard_d;
    logic       sticky_q, sticky_d;
    logic [2:0] exp_q, exp_d;
    logic       swap_q, swap_d;

    logic [4:0] sig_a, sig_b;
    logic [2:0] shamt;
    logic       unused_diff_msb;

    assign sig_a = {|Exp_A, Man_A};
    assign sig_b = {|Exp_B, Man_B};
    assign unused_diff_msb = Exp_diff[3];

    // Low 3 bits of the 4-bit negation equal the 3-bit negation of the low bits.
    always_comb begin
        shamt = 3'd0;
        if (Same_exp)
            shamt = 3'd0;
        else if (Co)
            shamt = Exp_diff[2:0];
        else
            shamt = ~Exp_diff[2:0] + 3'd1;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        big_d    = big_q;
        small_d  = small_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        exp_d    = exp_q;
        swap_d   = swap_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (Same_exp || Co) begin
                        big_d   = sig_a;
                        small_d = sig_b;
                        exp_d   = Exp_A;
                        swap_d  = 1'b0;
                    end else begin
                        big_d   = sig_b;
                        small_d = sig_a;
                        exp_d   = Exp_B;
                        swap_d  = 1'b1;
                    end
                    guard_d  = 1'b0;
                    sticky_d = 1'b0;
                    cnt_d    = shamt;
                    state_d  = (shamt == 3'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                sticky_d = sticky_q | guard_q;
                guard_d  = small_q[0];
                small_d  = small_q >> 1;
                cnt_d    = cnt_q - 3'd1;
                if (cnt_q == 3'd1)
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            big_q    <= 5'd0;
            small_q  <= 5'd0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            exp_q    <= 3'd0;
            swap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            big_q    <= big_d;
            small_q  <= small_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            exp_q    <= exp_d;
            swap_q   <= swap_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Man_big   = big_q;
    assign Man_small = small_q;
    assign Guard     = guard_q;
    assign Sticky    = sticky_q;
    assign Exp_res   = exp_q;
    assign Swap      = swap_q;

endmodule

// File: tb/tb_mant_align.sv
// Bench for mant_align: arithmetic reference model feeding a scoreboard queue, drained by an output monitor.
module tb_mant_align;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [2:0] Exp_A, Exp_B;
    logic [3:0] Man_A, Man_B, Exp_diff;
    logic       Co, Same_exp;
    logic       out_valid, out_ready;
    logic [4:0] Man_big, Man_small;
    logic       Guard, Sticky, Swap;
    logic [2:0] Exp_res;

    mant_align dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Exp_A(Exp_A), .Exp_B(Exp_B), .Man_A(Man_A), .Man_B(Man_B),
        .Exp_diff(Exp_diff), .Co(Co), .Same_exp(Same_exp),
        .out_valid(out_valid), .out_ready(out_ready),
        .Man_big(Man_big), .Man_small(Man_small), .Guard(Guard), .Sticky(Sticky),
        .Exp_res(Exp_res), .Swap(Swap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0] big;
        logic [4:0] sml;
        logic       g;
        logic       s;
        logic [2:0] e;
        logic       sw;
        int         n;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Alignment computed directly: the shifted-out bits are just the low n bits of the small significand.
    function automatic exp_t model(input int ea, input int eb, input int ma, input int mb);
        exp_t r;
        int sa, sb, sm, n;
        sa = ((ea != 0) ? 16 : 0) + ma;
        sb = ((eb != 0) ? 16 : 0) + mb;
        if (eb > ea) begin
            r.big = 5'(sb); sm = sa; n = eb - ea; r.e = 3'(eb); r.sw = 1'b1;
        end else begin
            r.big = 5'(sa); sm = sb; n = ea - eb; r.e = 3'(ea); r.sw = 1'b0;
        end
        r.sml = 5'(sm >> n);
        r.g   = (n == 0) ? 1'b0 : 1'((sm >> (n - 1)) & 1);
        r.s   = (n <= 1) ? 1'b0 : ((sm & ((1 << (n - 1)) - 1)) != 0);
        r.n   = n;
        r.acc = 0;
        return r;
    endfunction

    task automatic junk_inputs();
        in_valid = 1'($urandom_range(0, 1));
        Exp_A    = 3'($urandom); Exp_B = 3'($urandom);
        Man_A    = 4'($urandom); Man_B = 4'($urandom);
        Exp_diff = 4'($urandom); Co = 1'($urandom); Same_exp = 1'($urandom);
    endtask

    // Returns at the negedge before the accepting edge, with the operation driven.
    task automatic issue(input int ea, input int eb, input int ma, input int mb, input bit push);
        exp_t e;
        int   waited = 0;
        logic [3:0] d4;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            junk_inputs();
            waited++;
            if (waited > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles", waited);
                break;
            end
        end
        Exp_A    = 3'(ea); Exp_B = 3'(eb);
        Man_A    = 4'(ma); Man_B = 4'(mb);
        d4       = 4'(ea - eb);
        Exp_diff = d4;
        Co       = (ea >= eb);
        Same_exp = (ea == eb);
        in_valid = 1'b1;
        if (push) begin
            e = model(ea, eb, ma, mb);
            e.acc = cyc + 1;
            q.push_back(e);
        end
    endtask

    logic [15:0] cur, snap;
    assign cur = {Man_big, Man_small, Guard, Sticky, Exp_res, Swap};

    // Monitor: owns out_ready, pops on each new result and checks holding under backpressure.
    initial begin
        exp_t e;
        bit holding = 0;
        bit prev_hs = 0;
        out_ready = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                holding = 0; prev_hs = 0; out_ready = 1'b0;
            end else if (prev_hs) begin
                chk("idle_after_hs_valid", 32'(out_valid), 32'd0);
                chk("idle_after_hs_ready", 32'(in_ready), 32'd1);
                prev_hs   = 0;
                out_ready = 1'($urandom_range(0, 1));
            end else if (out_valid) begin
                chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
                if (!holding) begin
                    if (q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_output: out_valid with empty scoreboard, outputs %0h", cur);
                    end else begin
                        e = q.pop_front();
                        chk("latency",   32'(cyc - e.acc), 32'(e.n));
                        chk("man_big",   32'(Man_big),   32'(e.big));
                        chk("man_small", 32'(Man_small), 32'(e.sml));
                        chk("guard",     32'(Guard),     32'(e.g));
                        chk("sticky",    32'(Sticky),    32'(e.s));
                        chk("exp_res",   32'(Exp_res),   32'(e.e));
                        chk("swap",      32'(Swap),      32'(e.sw));
                    end
                    snap    = cur;
                    holding = 1;
                end else begin
                    chk("hold_stable", 32'(cur), 32'(snap));
                end
                out_ready = ($urandom_range(0, 2) == 0);
                if (out_ready) begin
                    prev_hs = 1; holding = 0;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        int waited;
        rst_n = 1'b0;
        in_valid = 1'b0;
        Exp_A = '0; Exp_B = '0; Man_A = '0; Man_B = '0;
        Exp_diff = '0; Co = 1'b0; Same_exp = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs",   32'(cur),       32'd0);
        rst_n = 1'b1;

        // Reset during the second SHIFT cycle of a 3-bit shift.
        issue(5, 2, 8, 6, 0);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midshift_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midshift_rst_in_ready",  32'(in_ready),  32'd1);
        chk("midshift_rst_outputs",   32'(cur),       32'd0);
        @(negedge clk); rst_n = 1'b1;

        issue(5, 2, 8, 6, 1);     // A larger, shift 3
        issue(1, 6, 15, 0, 1);    // B larger, shift 5
        issue(4, 4, 3, 5, 1);     // equal exponents
        issue(0, 7, 1, 9, 1);     // zero exponent, shift 7
        issue(7, 0, 0, 15, 1);    // A larger by 7, hidden bit of B clear
        for (int i = 0; i < 200; i++)
            issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15), 1);

        waited = 0;
        @(negedge clk); in_valid = 1'b0;
        while ((q.size() != 0 || out_valid) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
        end
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
